gf180mcu_as_sc_mcu7t3v3_dfx_bank: RTL

- Parametrised multi-bit, multi-stage flip-flop bank macro for the 7-track 3.3 V library.
- Next generation of the single-bit positive-edge D flop. Adds width and depth generalisation, a synchronous reset to a parametrised value, hold, a valid-tracking pipeline, and a built-in scan/rotate chain.
- Used as a drop-in pipeline register and as a DFT-observable register bank in digital blocks built on this library.

---
 rtl/gf180mcu_as_sc_mcu7t3v3_dfx_bank.sv | 53 +++++
 1 files changed

// File: rtl/gf180mcu_as_sc_mcu7t3v3_dfx_bank.sv
// gf180mcu_as_sc_mcu7t3v3_dfx_bank: parametrised pipeline flop bank with valid tracking and scan/rotate chain
//   CLK/RST          clock and synchronous active-high reset to RESET_VAL
//   VPW/VNW/VDD/VSS  bias and supply pins, no logical function
//   MODE             00 hold, 01 capture, 10 scan (SI in), 11 rotate (SO fed back)
//   D/DV             parallel data and valid into stage 0
//   SI/SO            serial chain input and output (SO = MSB of last stage)
//   Q/QV             last stage data and valid, straight from the registers
module gf180mcu_as_sc_mcu7t3v3_dfx_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VPW,
  input  logic             VNW,
  input  logic             VDD,
  input  logic             VSS,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic             SO
);
  localparam int N = WIDTH * DEPTH;
  // Stage i occupies chain bits [i*WIDTH +: WIDTH], so one left shift walks the scan order
  // and a WIDTH-bit shift advances the pipeline by one stage.
  logic [N-1:0]     chain_q, chain_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             sin;
  logic             unused_pwr;
  assign unused_pwr = ^{VPW, VNW, VDD, VSS};
  always_comb begin
    sin     = MODE[0] ? chain_q[N-1] : SI;
    chain_d = MODE[1] ? ((chain_q << 1) | N'(sin)) :
              MODE[0] ? ((chain_q << WIDTH) | N'(D)) : chain_q;
    vld_d   = (MODE == 2'b01) ? ((vld_q << 1) | DEPTH'(DV)) : vld_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      chain_q <= {DEPTH{RESET_VAL}};
      vld_q   <= '0;
    end else begin
      chain_q <= chain_d;
      vld_q   <= vld_d;
    end
  end
  assign Q  = chain_q[N-1 -: WIDTH];
  assign QV = vld_q[DEPTH-1];
  assign SO = chain_q[N-1];
endmodule
